// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection sequencer with an optional pedestrian phase after AR2.
// Lamps and BCD digits are decoded from the registered state and countdown.
module traffic_intersection_ctrl #(
    parameter int CNT_WIDTH   = 6,
    parameter int GREEN_TIME  = 14,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    parameter int PED_TIME    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 ped_req,
    output logic                 ns_red,
    output logic                 ns_yel,
    output logic                 ns_grn,
    output logic                 ew_red,
    output logic                 ew_yel,
    output logic                 ew_grn,
    output logic                 ped_walk,
    output logic [2:0]           phase,
    output logic [CNT_WIDTH-1:0] count,
    output logic [3:0]           bcd_tens,
    output logic [3:0]           bcd_ones
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NS_GRN = 3'd1,
        NS_YEL = 3'd2,
        AR1    = 3'd3,
        EW_GRN = 3'd4,
        EW_YEL = 3'd5,
        AR2    = 3'd6,
        PED    = 3'd7
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 ped_pending;
    logic                 ped_clr;
    logic [6:0]           cnt7;

    function automatic logic [CNT_WIDTH-1:0] dwell(input state_t s);
        case (s)
            NS_GRN, EW_GRN: dwell = CNT_WIDTH'(GREEN_TIME);
            NS_YEL, EW_YEL: dwell = CNT_WIDTH'(YELLOW_TIME);
            AR1, AR2:       dwell = CNT_WIDTH'(ALLRED_TIME);
            PED:            dwell = CNT_WIDTH'(PED_TIME);
            default:        dwell = '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= cnt_nxt;
        end
    end

    // A new request on the PED entry edge outranks the clear, so it is served next rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ped_pending <= 1'b0;
        else if (ped_req) ped_pending <= 1'b1;
        else if (ped_clr) ped_pending <= 1'b0;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = count;
        ped_clr   = 1'b0;
        if (state == IDLE) begin
            if (en) begin
                state_nxt = NS_GRN;
                cnt_nxt   = dwell(NS_GRN);
            end
        end else if (en) begin
            if (count != '0) begin
                cnt_nxt = count - CNT_WIDTH'(1);
            end else begin
                case (state)
                    NS_GRN:  state_nxt = NS_YEL;
                    NS_YEL:  state_nxt = AR1;
                    AR1:     state_nxt = EW_GRN;
                    EW_GRN:  state_nxt = EW_YEL;
                    EW_YEL:  state_nxt = AR2;
                    AR2:     state_nxt = ped_pending ? PED : NS_GRN;
                    PED:     state_nxt = NS_GRN;
                    default: state_nxt = IDLE;
                endcase
                cnt_nxt = dwell(state_nxt);
                ped_clr = (state_nxt == PED);
            end
        end
    end

    always_comb begin
        ns_red   = 1'b1;
        ns_yel   = 1'b0;
        ns_grn   = 1'b0;
        ew_red   = 1'b1;
        ew_yel   = 1'b0;
        ew_grn   = 1'b0;
        ped_walk = 1'b0;
        case (state)
            NS_GRN:  begin ns_red = 1'b0; ns_grn = 1'b1; end
            NS_YEL:  begin ns_red = 1'b0; ns_yel = 1'b1; end
            EW_GRN:  begin ew_red = 1'b0; ew_grn = 1'b1; end
            EW_YEL:  begin ew_red = 1'b0; ew_yel = 1'b1; end
            PED:     ped_walk = 1'b1;
            default: ;
        endcase
    end

    assign phase    = state;
    assign cnt7     = 7'(count);
    assign bcd_tens = 4'(cnt7 / 7'd10);
    assign bcd_ones = 4'(cnt7 % 7'd10);

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed scenarios plus randomized en/ped_req/rst, all checked each cycle
// against a table-driven phase model.
module tb_traffic_intersection_ctrl;

    logic       clk = 1'b0;
    logic       rst, en, ped_req;
    logic       ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, ped_walk;
    logic [2:0] phase;
    logic [5:0] count;
    logic [3:0] bcd_tens, bcd_ones;

    int checks = 0;
    int errors = 0;

    // Model: phase number, remaining count, pending request.
    int m_ph, m_cnt, m_pend;
    int succ [8]    = '{1, 2, 3, 4, 5, 6, 1, 1};
    int dwell_t [8] = '{0, 14, 2, 1, 14, 2, 1, 9};
    // {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, ped_walk}
    logic [6:0] lamp_tbl [8] = '{7'b100_100_0, 7'b001_100_0, 7'b010_100_0, 7'b100_100_0,
                                 7'b100_001_0, 7'b100_010_0, 7'b100_100_0, 7'b100_100_1};

    traffic_intersection_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .ped_req(ped_req),
        .ns_red(ns_red), .ns_yel(ns_yel), .ns_grn(ns_grn),
        .ew_red(ew_red), .ew_yel(ew_yel), .ew_grn(ew_grn),
        .ped_walk(ped_walk), .phase(phase), .count(count),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_pend = 0;
    endtask

    task automatic check_all();
        int ok;
        check("phase", int'(phase), m_ph);
        check("count", int'(count), m_cnt);
        check("bcd_tens", int'(bcd_tens), m_cnt / 10);
        check("bcd_ones", int'(bcd_ones), m_cnt % 10);
        check("lamps", int'({ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, ped_walk}),
              int'(lamp_tbl[m_ph]));
        ok = int'(!(ns_grn && ew_grn)) & int'(!ped_walk || (ns_red && ew_red))
           & int'((int'(ns_red) + int'(ns_yel) + int'(ns_grn)) <= 1)
           & int'((int'(ew_red) + int'(ew_yel) + int'(ew_grn)) <= 1);
        check("lamp_excl", ok, 1);
    endtask

    // One clock: model samples inputs at the rising edge, outputs compared at the falling edge.
    task automatic tick();
        int nxt;
        int entering;
        @(posedge clk);
        entering = 0;
        if (rst) model_reset();
        else begin
            if (m_ph == 0) begin
                if (en) begin m_ph = 1; m_cnt = dwell_t[1]; end
            end else if (en) begin
                if (m_cnt > 0) m_cnt--;
                else begin
                    nxt = (m_ph == 6) ? (m_pend != 0 ? 7 : 1) : succ[m_ph];
                    entering = int'(nxt == 7);
                    m_ph = nxt;
                    m_cnt = dwell_t[nxt];
                end
            end
            if (ped_req) m_pend = 1;
            else if (entering != 0) m_pend = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_for(input int p, input int c);
        int n = 0;
        while (!(m_ph == p && m_cnt == c) && n < 300) begin tick(); n++; end
        check($sformatf("reach_%0d_%0d", p, c), int'(m_ph == p && m_cnt == c), 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; ped_req = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0; en = 1'b1;

        // Free-running cycle and its period.
        tick();
        check("first_ns_cnt", int'(count), 14);
        check("first_tens", int'(bcd_tens), 1);
        check("first_ones", int'(bcd_ones), 4);
        n = 0;
        do begin tick(); n++; end while (!(m_ph == 1 && m_cnt == 14) && n < 100);
        check("period", n, 40);

        // Single-cycle request during EW_GRN.
        wait_for(4, 10);
        ped_req = 1'b1; tick(); ped_req = 1'b0;
        wait_for(7, 9);
        n = 0;
        while (m_ph == 7 && n < 50) begin
            check("walk_on", int'(ped_walk), 1);
            n++; tick();
        end
        check("walk_len", n, 10);
        check("after_ped_phase", int'(phase), 1);
        check("after_ped_cnt", int'(count), 14);
        wait_for(6, 0);
        tick();
        check("ped_skipped", int'(phase), 1);

        // Enable hold.
        wait_for(1, 7);
        en = 1'b0;
        repeat (5) begin
            tick();
            check("hold_cnt", int'(count), 7);
            check("hold_grn", int'(ns_grn), 1);
        end
        en = 1'b1;
        tick(); check("resume6", int'(count), 6);
        tick(); check("resume5", int'(count), 5);

        // Async reset mid EW_YEL with a request outstanding.
        wait_for(4, 5);
        ped_req = 1'b1; tick(); ped_req = 1'b0;
        wait_for(5, 1);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all();
        check("rst_phase", int'(phase), 0);
        check("rst_ew_red", int'(ew_red), 1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_phase", int'(phase), 1);
        check("post_rst_cnt", int'(count), 14);
        wait_for(6, 0);
        tick();
        check("req_dropped_by_rst", int'(phase), 1);

        // Request held across PED entry: served again next rotation.
        wait_for(4, 3);
        ped_req = 1'b1;
        wait_for(7, 9);
        tick(); tick();
        ped_req = 1'b0;
        wait_for(6, 0);
        tick();
        check("ped_again", int'(phase), 7);

        // Randomized traffic.
        repeat (2000) begin
            en      = ($urandom_range(0, 9) != 0);
            ped_req = ($urandom_range(0, 19) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_intersection_ctrl.md
TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 6: countdown width; legal range 4..6.
REQ-002 SHALL have parameter GREEN_TIME, default 14: green dwell minus one, in enabled cycles.
REQ-003 SHALL have parameter YELLOW_TIME, default 2: yellow dwell minus one.
REQ-004 SHALL have parameter ALLRED_TIME, default 1: all-red clearance dwell minus one.
REQ-005 SHALL have parameter PED_TIME, default 9: pedestrian walk dwell minus one; every *_TIME SHALL be ≤ min(2^CNT_WIDTH-1, 63).
REQ-006 SHALL have port clk, input, 1: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port en, input, 1: advance enable.
REQ-009 SHALL have port ped_req, input, 1: pedestrian request, level or pulse, sampled every clk.
REQ-010 SHALL have ports ns_red, ns_yel, ns_grn, output, 1 each: north-south lamps.
REQ-011 SHALL have ports ew_red, ew_yel, ew_grn, output, 1 each: east-west lamps.
REQ-012 SHALL have port ped_walk, output, 1: walk lamp.
REQ-013 SHALL have port phase, output, 3: current state code.
REQ-014 SHALL have port count, output, CNT_WIDTH: remaining countdown.
REQ-015 SHALL have ports bcd_tens and bcd_ones, output, 4 each: decimal digits of count.

Function
REQ-016 SHALL implement the states and phase codes IDLE=0, NS_GRN=1, NS_YEL=2, AR1=3, EW_GRN=4, EW_YEL=5, AR2=6, PED=7.
REQ-017 SHALL follow the state order IDLE→NS_GRN→NS_YEL→AR1→EW_GRN→EW_YEL→AR2, then AR2→PED if ped_pending=1, else AR2→NS_GRN; PED→NS_GRN.
REQ-018 SHALL move IDLE→NS_GRN on the first clk with en=1 and load count with GREEN_TIME.
REQ-019 SHALL load count on entry to a state with that state's *_TIME (AR1 and AR2 use ALLRED_TIME).
REQ-020 SHALL, on each clk with en=1 and count≠0, decrement count by 1.
REQ-021 SHALL, on each clk with en=1 and count=0, take the transition and load the next state's value in the same edge; each state therefore lasts *_TIME+1 enabled cycles.
REQ-022 SHALL, with en=0 and state≠IDLE, hold state and count unchanged; count SHALL never wrap below 0.
REQ-023 SHALL drive lamps as a registered-state decode: in each road's green or yellow state only that road's matching lamp is 1 and the other road shows red; in AR1, AR2, PED and IDLE both reds are 1.
REQ-024 SHALL assert ped_walk only in PED and SHALL never assert any two lamps of one road simultaneously.
REQ-025 SHALL set an internal ped_pending flag on any clk with ped_req=1, regardless of en.
REQ-026 SHALL clear ped_pending on the edge entering PED, except that set wins when ped_req=1 on that same edge (request served on the next rotation).
REQ-027 SHALL drive bcd_tens=count/10 and bcd_ones=count%10 combinationally from count.
REQ-028 SHALL hold count=0 in IDLE.

Reset
REQ-029 SHALL, while rst=1, immediately force state=IDLE, count=0, ped_pending=0, ns_red=ew_red=1, all other lamps and ped_walk 0, phase=0, bcd_tens=bcd_ones=0, regardless of clk.
REQ-030 SHALL, on rst deassertion mid-operation, restart only via IDLE→NS_GRN with en=1; no prior request SHALL survive reset.

Verification
REQ-031 SHALL be verified with defaults, rst released, en=1 and no ped_req: NS_GRN 15 cycles (count 14..0, first tens/ones 1/4), NS_YEL 3, AR1 2, EW_GRN 15, EW_YEL 3, AR2 2, then NS_GRN; period 40 cycles.
REQ-032 SHALL be verified with a one-cycle ped_req pulse during EW_GRN: AR2→PED, ped_walk=1 for 10 cycles with all reds on, then NS_GRN with count=14; next rotation skips PED.
REQ-033 SHALL be verified with en=0 for 5 cycles at NS_GRN count=7: state, count and lamps frozen; after en=1, count resumes 6,5,…
REQ-034 SHALL be verified with rst pulsed asynchronously between edges during EW_YEL: outputs return to the IDLE/reset values within the pulse; after release and en=1, NS_GRN with count=14.
REQ-035 SHALL be verified with ped_req held high across PED entry: PED served, then pending remains 1, so the next AR2 enters PED again.
REQ-036 SHALL be verified with a 2-state lamp-exclusion assertion checked every cycle: no green on both roads, and ped_walk=1 implies both reds=1.
